// File: rtl/strided_buffer_loader.sv
// strided_buffer_loader: steers a 64-bit AXI-Stream of layer data into the
// weight buffer and then kernel buffers 0..N_KERNEL-1, in that fixed order.
// Each buffer takes ceil(C/4)*H*W words. Its tlast framing is checked.
// Ports:
//   clk, rstn         clock, async active-low reset
//   layer_para        [47:0] weight shape, [95:48] kernel shape (C,H,W)
//   start/busy/done   load request, in-progress flag, completion pulse
//   err               sticky tlast framing error, cleared by accepted start
//   s_tdata/s_tvalid/s_tlast/s_tready  input stream
//   wb_clr/wb_we/wb_full   weight buffer clear, write, almost-full
//   kb_clr/kb_we/kb_full   kernel buffer clears, one-hot writes, almost-full
//   di                write data shared by all buffers
module strided_buffer_loader #(
   parameter int unsigned N_KERNEL    = 3,
   parameter int unsigned B_SHAPE     = 48,
   parameter int unsigned B_LAYERPARA = 96,
   parameter int unsigned DATA_WIDTH  = 64,
   parameter int unsigned B_COORD     = 16
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [B_LAYERPARA-1:0] layer_para,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   input  logic [DATA_WIDTH-1:0]  s_tdata,
   input  logic                   s_tvalid,
   input  logic                   s_tlast,
   output logic                   s_tready,
   output logic                   wb_clr,
   output logic                   wb_we,
   input  logic                   wb_full,
   output logic [N_KERNEL-1:0]    kb_clr,
   output logic [N_KERNEL-1:0]    kb_we,
   input  logic [N_KERNEL-1:0]    kb_full,
   output logic [DATA_WIDTH-1:0]  di
);

   localparam int unsigned K_W = (N_KERNEL > 1) ? $clog2(N_KERNEL) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_LD_WEI,
      S_LD_KER,
      S_DONE
   } state_t;

   state_t                 state, state_nxt;
   logic [B_SHAPE-1:0]     wei_shape, wei_nxt;
   logic [B_SHAPE-1:0]     ker_shape, ker_nxt;
   logic [B_COORD-1:0]     cw, cw_nxt, x, x_nxt, y, y_nxt;
   logic [K_W-1:0]         k, k_nxt;
   logic                   busy_nxt, done_nxt, err_nxt;
   logic                   wb_clr_nxt, wb_we_nxt;
   logic [N_KERNEL-1:0]    kb_clr_nxt, kb_we_nxt;
   logic [DATA_WIDTH-1:0]  di_nxt;

   logic [B_SHAPE-1:0]     cur_shape;
   logic [B_COORD-1:0]     cur_c, cur_h, cur_w, cw_max;
   logic [B_COORD:0]       c_round;
   logic                   last_word, wei_zero, ker_zero, adv;

   // A shape with any zero dimension means the buffer gets no words.
   function automatic logic shape_zero(input logic [B_SHAPE-1:0] s);
      return (s[15:0] == 16'd0) || (s[31:16] == 16'd0) || (s[47:32] == 16'd0);
   endfunction

   // Geometry of the buffer currently being loaded.
   always_comb begin
      cur_shape = (state == S_LD_KER) ? ker_shape : wei_shape;
      cur_c     = B_COORD'(cur_shape[15:0]);
      cur_h     = B_COORD'(cur_shape[31:16]);
      cur_w     = B_COORD'(cur_shape[47:32]);
      c_round   = {1'b0, cur_c} + (B_COORD+1)'(3);
      cw_max    = B_COORD'(c_round >> 2) - B_COORD'(1);
      last_word = (cw == cw_max) && (x == cur_w - B_COORD'(1)) &&
                  (y == cur_h - B_COORD'(1));
      wei_zero  = shape_zero(wei_shape);
      ker_zero  = shape_zero(ker_shape);
   end

   // Next-state, stream handshake and registered-output next values.
   always_comb begin
      state_nxt  = state;
      wei_nxt    = wei_shape;
      ker_nxt    = ker_shape;
      cw_nxt     = cw;
      x_nxt      = x;
      y_nxt      = y;
      k_nxt      = k;
      busy_nxt   = busy;
      done_nxt   = 1'b0;
      err_nxt    = err;
      wb_we_nxt  = 1'b0;
      kb_we_nxt  = '0;
      di_nxt     = di;
      s_tready   = 1'b0;
      adv        = 1'b0;

      case (state)
         S_IDLE: begin
            // done marks the DONE cycle as seen outside; a start there is ignored.
            if (start && !done) begin
               wei_nxt   = layer_para[B_SHAPE-1:0];
               ker_nxt   = layer_para[2*B_SHAPE-1:B_SHAPE];
               err_nxt   = 1'b0;
               busy_nxt  = 1'b1;
               state_nxt = S_CLR;
            end
         end
         S_CLR: begin
            cw_nxt = '0;
            x_nxt  = '0;
            y_nxt  = '0;
            k_nxt  = '0;
            if (!wei_zero)      state_nxt = S_LD_WEI;
            else if (!ker_zero) state_nxt = S_LD_KER;
            else                state_nxt = S_DONE;
         end
         S_LD_WEI: begin
            s_tready = !wb_full;
            if (s_tvalid && s_tready) begin
               adv       = 1'b1;
               wb_we_nxt = 1'b1;
               if (last_word) begin
                  k_nxt     = '0;
                  state_nxt = ker_zero ? S_DONE : S_LD_KER;
               end
            end
         end
         S_LD_KER: begin
            s_tready = !kb_full[k];
            if (s_tvalid && s_tready) begin
               adv       = 1'b1;
               kb_we_nxt = N_KERNEL'(1) << k;
               if (last_word) begin
                  if (k == K_W'(N_KERNEL - 1)) state_nxt = S_DONE;
                  else                         k_nxt     = k + K_W'(1);
               end
            end
         end
         S_DONE: begin
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase

      // Accepted beat: capture data, check framing, step cw -> x -> y.
      if (adv) begin
         di_nxt = s_tdata;
         if (s_tlast != last_word) err_nxt = 1'b1;
         if (last_word) begin
            cw_nxt = '0;
            x_nxt  = '0;
            y_nxt  = '0;
         end else if (cw != cw_max) begin
            cw_nxt = cw + B_COORD'(1);
         end else begin
            cw_nxt = '0;
            if (x != cur_w - B_COORD'(1)) begin
               x_nxt = x + B_COORD'(1);
            end else begin
               x_nxt = '0;
               y_nxt = y + B_COORD'(1);
            end
         end
      end

      wb_clr_nxt = (state_nxt == S_CLR);
      kb_clr_nxt = {N_KERNEL{state_nxt == S_CLR}};
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= S_IDLE;
         wei_shape <= '0;
         ker_shape <= '0;
         cw        <= '0;
         x         <= '0;
         y         <= '0;
         k         <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         wb_clr    <= 1'b0;
         wb_we     <= 1'b0;
         kb_clr    <= '0;
         kb_we     <= '0;
         di        <= '0;
      end else begin
         state     <= state_nxt;
         wei_shape <= wei_nxt;
         ker_shape <= ker_nxt;
         cw        <= cw_nxt;
         x         <= x_nxt;
         y         <= y_nxt;
         k         <= k_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         err       <= err_nxt;
         wb_clr    <= wb_clr_nxt;
         wb_we     <= wb_we_nxt;
         kb_clr    <= kb_clr_nxt;
         kb_we     <= kb_we_nxt;
         di        <= di_nxt;
      end
   end

endmodule

// File: tb/tb_strided_buffer_loader.sv
// Scoreboard bench for strided_buffer_loader: the driver pushes the expected
// (target buffer, data) of every beat it sends. A negedge monitor pops and
// compares on each write pulse and checks err/latency on each done pulse.
module tb_strided_buffer_loader;

   localparam int unsigned NK = 3;

   logic          clk = 1'b0;
   logic          rstn;
   logic [95:0]   layer_para;
   logic          start;
   logic          busy, done, err;
   logic [63:0]   s_tdata;
   logic          s_tvalid, s_tlast, s_tready;
   logic          wb_clr, wb_we, wb_full;
   logic [NK-1:0] kb_clr, kb_we, kb_full;
   logic [63:0]   di;

   always #5 clk = ~clk;

   strided_buffer_loader #(.N_KERNEL(NK)) dut (
      .clk(clk), .rstn(rstn), .layer_para(layer_para), .start(start),
      .busy(busy), .done(done), .err(err),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
      .wb_clr(wb_clr), .wb_we(wb_we), .wb_full(wb_full),
      .kb_clr(kb_clr), .kb_we(kb_we), .kb_full(kb_full), .di(di)
   );

   typedef struct { int tgt; logic [63:0] data; } wr_t;
   typedef struct { logic err; bit any; } dn_t;

   wr_t exp_q[$];
   dn_t done_q[$];
   int  checks = 0, passed = 0;
   int  n_we = 0, n_wb = 0, n_done = 0, cyc = 0, last_we_cyc = 0;
   int  gap_pct = 0;
   bit  rnd_full = 0;

   int  mon_t;
   wr_t mon_e;
   dn_t mon_d;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Reference: words per buffer straight from the shape arithmetic.
   function automatic int words(input logic [47:0] s);
      int c, h, w;
      c = int'(s[15:0]);
      h = int'(s[31:16]);
      w = int'(s[47:32]);
      if (c == 0 || h == 0 || w == 0) return 0;
      return ((c + 3) / 4) * h * w;
   endfunction

   function automatic logic [47:0] shape(input int c, input int h, input int w);
      return {16'(w), 16'(h), 16'(c)};
   endfunction

   // Monitor: compare every write and every done against the scoreboard.
   always @(negedge clk) begin
      cyc++;
      if (rstn) begin
         if (wb_we || kb_we != '0) begin
            mon_t = -1;
            if (wb_we && kb_we == '0) mon_t = 0;
            else if (!wb_we && $onehot(kb_we))
               for (int i = 0; i < NK; i++) if (kb_we[i]) mon_t = i + 1;
            n_we++;
            if (wb_we) n_wb++;
            last_we_cyc = cyc;
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_write: target %0d di %0h, expected no write", mon_t, di);
            end else begin
               mon_e = exp_q.pop_front();
               chk("wr_target", 64'(mon_t), 64'(mon_e.tgt));
               chk("wr_data", di, mon_e.data);
            end
         end
         if (done) begin
            n_done++;
            if (done_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_done: done=1, expected 0");
            end else begin
               mon_d = done_q.pop_front();
               chk("err_at_done", 64'(err), 64'(mon_d.err));
               chk("busy_at_done", 64'(busy), 64'(0));
               chk("writes_left_at_done", 64'(exp_q.size()), 64'(0));
               if (mon_d.any) chk("done_latency", 64'(cyc - last_we_cyc), 64'(1));
            end
         end
      end
   end

   // Random almost-full toggling, applied away from the driver's update time.
   initial forever begin
      @(posedge clk);
      #2;
      if (rnd_full) begin
         wb_full = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < NK; i++) kb_full[i] = ($urandom_range(0, 3) == 0);
      end
   end

   task automatic chk_reset_outputs();
      chk("reset_ctl", 64'({busy, done, err, s_tready, wb_clr, wb_we, kb_clr, kb_we}), 64'(0));
      chk("reset_di", di, 64'(0));
   endtask

   task automatic do_start(input logic [95:0] para, input bit any);
      @(posedge clk);
      #1;
      layer_para = para;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      layer_para = {$urandom, $urandom, $urandom};
      @(negedge clk);
      chk("clr_cycle", 64'({busy, err, wb_clr, kb_clr}), 64'({1'b1, 1'b0, 1'b1, {NK{1'b1}}}));
      @(posedge clk);
      #1;
      if (!rnd_full) begin
         @(negedge clk);
         chk("ready_after_clr", 64'(s_tready), 64'(any));
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_word(input logic [63:0] d, input logic tl, output bit ok);
      logic acc;
      s_tdata = d;
      s_tlast = tl;
      s_tvalid = 1'b1;
      ok = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         acc = s_tready;
         @(posedge clk);
         #1;
         if (acc) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         $display("FAIL beat_timeout: word not accepted in 500 cycles, expected acceptance");
      end
   endtask

   // One complete load: bad_idx flips tlast on that weight word, abort_at
   // resets after that many words, glitch_at raises start mid-load.
   task automatic send_load(input logic [95:0] para, input int bad_idx,
                            input int abort_at, input int glitch_at);
      int nw, nk, n, idx, n0;
      logic [63:0] d;
      bit ok;
      nw = words(para[47:0]);
      nk = words(para[95:48]);
      done_q.push_back('{(bad_idx >= 0 && bad_idx < nw), (nw + nk * NK) > 0});
      n0 = n_done;
      do_start(para, (nw + nk) > 0);
      idx = 0;
      for (int b = 0; b <= NK; b++) begin
         n = (b == 0) ? nw : nk;
         for (int i = 0; i < n; i++) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
               s_tvalid = 1'b0;
               @(posedge clk);
               #1;
            end
            if (idx == glitch_at) begin
               start = 1'b1;
               layer_para = {$urandom, $urandom, $urandom};
            end
            d = {$urandom, $urandom};
            exp_q.push_back('{b, d});
            send_word(d, (i == n - 1) ^ (b == 0 && i == bad_idx), ok);
            start = 1'b0;
            idx++;
            if (idx == abort_at) begin
               s_tvalid = 1'b0;
               @(negedge clk);
               #1;
               rstn = 1'b0;
               #1;
               chk_reset_outputs();
               exp_q.delete();
               done_q.delete();
               @(posedge clk);
               #1;
               rstn = 1'b1;
               return;
            end
         end
      end
      s_tvalid = 1'b0;
      s_tlast = 1'b0;
      for (int i = 0; i < 50 && n_done == n0; i++) @(negedge clk);
      if (n_done == n0) begin
         checks++;
         $display("FAIL done_timeout: no done within 50 cycles, expected done");
      end
   endtask

   // Hold kb_full[1] for 5 cycles once kernel 1 has taken its first word.
   task automatic full_watch();
      bit seen = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (kb_we[1]) seen = 1;
      end
      if (!seen) begin
         checks++;
         $display("FAIL full_watch: no kernel-1 write seen, expected one");
      end else begin
         kb_full[1] = 1'b1;
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("ready_low_while_full", 64'(s_tready), 64'(0));
         end
         @(posedge clk);
         #1;
         kb_full[1] = 1'b0;
         @(negedge clk);
         chk("ready_after_full", 64'(s_tready), 64'(1));
      end
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [95:0] p1, p;
      int we0, wb0, nw;
      rstn = 1'b0;
      start = 1'b0;
      layer_para = '0;
      s_tdata = '0;
      s_tvalid = 1'b0;
      s_tlast = 1'b0;
      wb_full = 1'b0;
      kb_full = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs();
      rstn = 1'b1;

      p1 = {shape(8, 1, 1), shape(4, 2, 2)};

      // Basic continuous load: 4 weight words then 2 per kernel.
      we0 = n_we; wb0 = n_wb;
      send_load(p1, -1, -1, -1);
      chk("basic_we_total", 64'(n_we - we0), 64'(10));
      chk("basic_wb_total", 64'(n_wb - wb0), 64'(4));

      // Kernel-1 almost-full throttles the stream without losing beats.
      we0 = n_we;
      fork
         full_watch();
      join_none
      send_load(p1, -1, -1, -1);
      chk("throttle_we_total", 64'(n_we - we0), 64'(10));

      // C=5 rounds up to two words per pixel.
      wb0 = n_wb;
      send_load({shape(4, 1, 1), shape(5, 1, 3)}, -1, -1, -1);
      chk("c5_wb_total", 64'(n_wb - wb0), 64'(6));

      // H=0 weight buffer is skipped entirely.
      wb0 = n_wb; we0 = n_we;
      send_load({shape(4, 1, 2), shape(4, 0, 2)}, -1, -1, -1);
      chk("h0_wb_total", 64'(n_wb - wb0), 64'(0));
      chk("h0_we_total", 64'(n_we - we0), 64'(6));

      // Early tlast on weight word 2 of 4: sticky err until next start.
      send_load(p1, 1, -1, -1);
      chk("err_sticky_idle", 64'(err), 64'(1));
      send_load(p1, -1, -1, -1);

      // Reset during kernel 1, then a clean reload.
      send_load(p1, -1, 7, -1);
      send_load(p1, -1, -1, -1);

      // Randomized shapes, gaps, fulls, framing errors and ignored starts.
      gap_pct = 30;
      rnd_full = 1;
      for (int t = 0; t < 25; t++) begin
         p = {shape($urandom_range(0, 9),
                    ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3),
                    $urandom_range(1, 3)),
              shape(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 9),
                    $urandom_range(1, 3), $urandom_range(1, 3))};
         nw = words(p[47:0]);
         send_load(p, ($urandom_range(0, 3) == 0 && nw > 0) ? $urandom_range(0, nw - 1) : -1,
                   -1, $urandom_range(0, 12));
      end
      rnd_full = 0;
      #1;
      wb_full = 1'b0;
      kb_full = '0;
      repeat (3) @(posedge clk);
      chk("queue_empty_at_end", 64'(exp_q.size() + done_q.size()), 64'(0));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/strided_buffer_loader.md
Name: strided_buffer_loader

Overview:
- Writer-side companion to the weight/kernel strided buffers.
- Accepts a 64-bit AXI-Stream of layer data from the DDR read DMA and steers it word by word into the weight buffer, then into kernel buffers 0..N_KERNEL-1, in that fixed order.
- Drives the buffers' clr/we/di inputs and throttles the stream when the target buffer reports full.
- Signals done/err to the layer sequencer.

Parameters:
N_KERNEL, 3, number of kernel buffers loaded after the weight buffer
B_SHAPE, 48, shape field width: [15:0]=C channels, [31:16]=H, [47:32]=W
B_LAYERPARA, 96, layer_para width: [47:0]=weight shape, [95:48]=kernel shape
DATA_WIDTH, 64, stream/buffer word width (4 pixels of 16 bits)
B_COORD, 16, width of the internal c/y/x counters

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
layer_para  in  B_LAYERPARA  shapes, sampled on accepted start
start  in  1  one-cycle load request; ignored while busy
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when all buffers are loaded
err  out  1  sticky tlast-framing error; cleared on accepted start
s_tdata  in  DATA_WIDTH  stream data
s_tvalid  in  1  stream valid
s_tlast  in  1  last word of current buffer
s_tready  out  1  stream ready
wb_clr  out  1  weight buffer clear pulse
wb_we  out  1  weight buffer write enable
wb_full  in  1  weight buffer almost-full (at most 1 free slot)
kb_clr  out  N_KERNEL  kernel buffer clear pulses
kb_we  out  N_KERNEL  kernel buffer write enables, one-hot
kb_full  in  N_KERNEL  kernel buffer almost-full flags
di  out  DATA_WIDTH  write data shared by all buffers

Behaviour:
- Reset, or rstn low at any time including mid-load, aborts any load. Outputs go to: state IDLE, busy=0, done=0, err=0, s_tready=0, wb_clr=0, wb_we=0, kb_clr=0, kb_we=0, di=0.
- State machine: IDLE -> CLR -> LD_WEI -> LD_KER -> DONE -> IDLE.
- IDLE:
  - start=1 latches both shapes, clears err, sets busy, goes to CLR.
- CLR:
  - Exactly one cycle.
  - wb_clr=1 and kb_clr = all ones.
  - Next state is LD_WEI.
- Word count per buffer is ceil(C/4)*H*W, realised with nested counters: cw (0..ceil(C/4)-1, fastest), then x (0..W-1), then y (0..H-1). No multiplier is used.
- If any shape field is 0, that buffer receives zero words. It is skipped with no cycle spent in its load state.
- LD_WEI / LD_KER(k):
  - s_tready = !full of the current target.
  - A beat is accepted when s_tvalid && s_tready.
  - For each accepted beat, the next cycle has di = s_tdata, plus wb_we=1 or kb_we[k]=1 for exactly one cycle. Latency is 1 registered cycle; this is why the full inputs are defined as almost-full.
  - Last word of a buffer: the weight buffer goes to LD_KER with k=0; kernel k goes to k+1; after k=N_KERNEL-1 the state goes to DONE.
  - Counters reset between buffers.
  - s_tready is 1 on the transition cycle, so back-to-back beats across a buffer boundary are accepted with no bubble.
- tlast check:
  - err is set if an accepted beat has s_tlast=1 on a word that is not the buffer's last word.
  - err is also set if the buffer's last word is accepted with s_tlast=0.
  - Loading continues by count regardless of err.
- DONE:
  - done=1 for one cycle; busy drops in the same cycle; s_tready=0.
  - The final we pulse precedes done by at least 1 cycle.
- Outside the LD states: s_tready=0 and all we outputs = 0.
- start while busy is ignored; latched shapes stay unchanged.
- A start in the DONE cycle is ignored. The earliest restart is the following cycle.
- Full toggling mid-word: s_tready follows it combinationally. No beat is lost or duplicated.

Test Plan:
- Weight shape C=4,H=2,W=2, kernel shape C=8,H=1,W=1, N_KERNEL=3, continuous valid, fulls low:
  - Expect 4 wb_we, then 2 kb_we[0], 2 kb_we[1], 2 kb_we[2] pulses.
  - di sequence matches the input order.
  - done 1 cycle after the last we; err=0.
- Same shapes, kb_full[1] high for 5 cycles after the first kernel-1 word: s_tready=0 for exactly those cycles, and the total we count is unchanged (10).
- Weight C=5 (ceil to 2 words), H=1, W=3: exactly 6 wb_we.
- Weight H=0: no wb_we; kernel loading starts the cycle after CLR.
- tlast asserted on word 2 of 4 of the weight buffer: err=1 and stays set through done. The next start clears it.
- rstn pulled low in the middle of LD_KER k=1: all outputs return to reset values immediately. After release a new start reloads from CLR, with wb_clr and kb_clr=3'b111 pulsed.
